// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// instr_fetch_ctrl: fetch controller between the PC register and instruction memory (req/ack, stall skid, flush kill).
// Optional macro FETCH_TIMEOUT_EN adds an 8-bit REQ watchdog that sets the sticky fetch_err_o and reissues.
module instr_fetch_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        pc_en_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        req_nxt;
  logic        valid_nxt;
  logic        kill;
  logic        kill_nxt;
  logic        pc_en;
  logic        timeout;
  logic [31:0] addr_nxt;
  logic [31:0] inst_nxt;
  logic [31:0] inst_pc_nxt;
  logic [31:0] skid_data;
  logic [31:0] skid_pc;
  logic [31:0] skid_data_nxt;
  logic [31:0] skid_pc_nxt;
  logic [31:0] pc_aligned;

  assign pc_aligned = pc_i & 32'hFFFF_FFFC;
  assign pc_en_o    = pc_en & ~rst_i;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err;

  // Fires on the 255th consecutive REQ cycle without an ack.
  assign timeout     = (state == REQ) && !imem_ack_i && (wait_cnt == 8'd254);
  assign fetch_err_o = err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= 8'd0;
      err      <= 1'b0;
    end else begin
      err <= err | timeout;
      if ((state == REQ) && !imem_ack_i && !timeout)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
    end
  end
`else
  assign timeout     = 1'b0;
  assign fetch_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      imem_req_o   <= 1'b0;
      imem_addr_o  <= 32'd0;
      inst_o       <= 32'd0;
      inst_pc_o    <= 32'd0;
      inst_valid_o <= 1'b0;
      kill         <= 1'b0;
      skid_data    <= 32'd0;
      skid_pc      <= 32'd0;
    end else begin
      state        <= state_nxt;
      imem_req_o   <= req_nxt;
      imem_addr_o  <= addr_nxt;
      inst_o       <= inst_nxt;
      inst_pc_o    <= inst_pc_nxt;
      inst_valid_o <= valid_nxt;
      kill         <= kill_nxt;
      skid_data    <= skid_data_nxt;
      skid_pc      <= skid_pc_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    req_nxt       = imem_req_o;
    addr_nxt      = imem_addr_o;
    inst_nxt      = inst_o;
    inst_pc_nxt   = inst_pc_o;
    valid_nxt     = inst_valid_o;
    kill_nxt      = kill;
    skid_data_nxt = skid_data;
    skid_pc_nxt   = skid_pc;
    pc_en         = 1'b0;

    case (state)
      IDLE: begin
        // A flush here loads the branch target into the PC on this edge, so wait one cycle for it.
        if (!flush_i) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          addr_nxt  = pc_aligned;
        end
      end
      REQ: begin
        if (imem_ack_i) begin
          if (flush_i) begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
            kill_nxt  = 1'b0;
          end else if (kill) begin
            kill_nxt = 1'b0;
            addr_nxt = pc_aligned;
          end else if (!stall_i) begin
            inst_nxt    = imem_data_i;
            inst_pc_nxt = imem_addr_o;
            valid_nxt   = 1'b1;
            pc_en       = 1'b1;
            req_nxt     = 1'b0;
            state_nxt   = IDLE;
          end else begin
            skid_data_nxt = imem_data_i;
            skid_pc_nxt   = imem_addr_o;
            req_nxt       = 1'b0;
            state_nxt     = HOLD;
          end
        end else if (timeout) begin
          req_nxt   = 1'b0;
          kill_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (flush_i) begin
          kill_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (!stall_i) begin
          inst_nxt    = skid_data;
          inst_pc_nxt = skid_pc;
          valid_nxt   = 1'b1;
          pc_en       = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase

    if (flush_i) begin
      pc_en     = 1'b1;
      valid_nxt = 1'b0;
      inst_nxt  = 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for instr_fetch_ctrl: directed vector table, hand sequences and a randomized model run.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        stall;
  logic        flush;
  logic        ack;
  logic [31:0] data;
  logic        pc_en;
  logic        req;
  logic [31:0] addr;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        valid;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pc_i         (pc_in),
    .pc_en_o      (pc_en),
    .stall_i      (stall),
    .flush_i      (flush),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_ack_i   (ack),
    .imem_data_i  (data),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .inst_valid_o (valid),
    .fetch_err_o  (err)
  );

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        ack;
    logic [31:0] data;
    logic        e_pc_en;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } held_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; ack = 1'b0; data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req", {31'd0, req}, 32'd0);
    chk("reset addr", addr, 32'd0);
    chk("reset valid", {31'd0, valid}, 32'd0);
    chk("reset inst", inst, 32'd0);
    chk("reset inst_pc", inst_pc, 32'd0);
    chk("reset pc_en", {31'd0, pc_en}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    pc_in = v.pc; stall = v.stall; flush = v.flush; ack = v.ack; data = v.data;
    #1;
    chk($sformatf("v%0d pc_en", idx), {31'd0, pc_en}, {31'd0, v.e_pc_en});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d req", idx), {31'd0, req}, {31'd0, v.e_req});
    chk($sformatf("v%0d addr", idx), addr, v.e_addr);
    chk($sformatf("v%0d valid", idx), {31'd0, valid}, {31'd0, v.e_valid});
    chk($sformatf("v%0d inst", idx), inst, v.e_inst);
    chk($sformatf("v%0d inst_pc", idx), inst_pc, v.e_ipc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        m_req, m_kill, m_valid, e_pc_en;
    logic [31:0] m_addr, m_inst, m_ipc, pcreg;
    held_t       held_q[$];

    //          pc            st  fl  ack data           pe  req addr          val inst           ipc
    vecs[0]  = '{32'h0000_0000, 0, 0, 0, 32'h0,          0, 1, 32'h0000_0000, 0, 32'h0,          32'h0};
    vecs[1]  = '{32'h0000_0000, 0, 0, 1, 32'h2002_0005,  1, 0, 32'h0000_0000, 1, 32'h2002_0005,  32'h0};
    vecs[2]  = '{32'h0000_0004, 0, 0, 0, 32'h0,          0, 1, 32'h0000_0004, 1, 32'h2002_0005,  32'h0};
    vecs[3]  = '{32'h0000_0004, 0, 0, 0, 32'h0,          0, 1, 32'h0000_0004, 1, 32'h2002_0005,  32'h0};
    vecs[4]  = '{32'h0000_0004, 1, 0, 1, 32'h1111_1111,  0, 0, 32'h0000_0004, 1, 32'h2002_0005,  32'h0};
    vecs[5]  = '{32'h0000_0004, 1, 0, 1, 32'h2222_2222,  0, 0, 32'h0000_0004, 1, 32'h2002_0005,  32'h0};
    vecs[6]  = '{32'h0000_0004, 1, 0, 0, 32'h0,          0, 0, 32'h0000_0004, 1, 32'h2002_0005,  32'h0};
    vecs[7]  = '{32'h0000_0004, 0, 0, 0, 32'h0,          1, 0, 32'h0000_0004, 1, 32'h1111_1111,  32'h4};
    vecs[8]  = '{32'h0000_0008, 0, 0, 0, 32'h0,          0, 1, 32'h0000_0008, 1, 32'h1111_1111,  32'h4};
    vecs[9]  = '{32'h0000_0008, 0, 1, 0, 32'h0,          1, 1, 32'h0000_0008, 0, 32'h0,          32'h4};
    vecs[10] = '{32'h0000_0040, 0, 0, 1, 32'hDEAD_BEEF,  0, 1, 32'h0000_0040, 0, 32'h0,          32'h4};
    vecs[11] = '{32'h0000_0040, 0, 0, 1, 32'h0000_0013,  1, 0, 32'h0000_0040, 1, 32'h0000_0013,  32'h40};
    vecs[12] = '{32'h0000_0044, 1, 1, 0, 32'h0,          1, 0, 32'h0000_0040, 0, 32'h0,          32'h40};
    vecs[13] = '{32'h0000_0080, 0, 0, 0, 32'h0,          0, 1, 32'h0000_0080, 0, 32'h0,          32'h40};
    vecs[14] = '{32'h0000_0080, 0, 1, 1, 32'hCAFE_0001,  1, 0, 32'h0000_0080, 0, 32'h0,          32'h40};
    vecs[15] = '{32'h0000_0103, 0, 0, 0, 32'h0,          0, 1, 32'h0000_0100, 0, 32'h0,          32'h40};
    vecs[16] = '{32'h0000_0100, 1, 0, 1, 32'h0BAD_F00D,  0, 0, 32'h0000_0100, 0, 32'h0,          32'h40};
    vecs[17] = '{32'h0000_0100, 1, 1, 0, 32'h0,          1, 0, 32'h0000_0100, 0, 32'h0,          32'h40};
    vecs[18] = '{32'h0000_0200, 0, 0, 0, 32'h0,          0, 1, 32'h0000_0200, 0, 32'h0,          32'h40};

    pc_in = 32'd0;
    do_reset();
    for (int i = 0; i < 19; i++) apply(vecs[i], i);

    // Ack delayed by five cycles: request and address stay put, no PC enable until the ack.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pc_in = 32'h200; stall = 1'b0; flush = 1'b0; ack = 1'b0;
      #1;
      chk("delay pc_en", {31'd0, pc_en}, 32'd0);
      @(posedge clk);
      #1;
      chk("delay req", {31'd0, req}, 32'd1);
      chk("delay addr", addr, 32'h200);
    end
    @(negedge clk);
    ack = 1'b1; data = 32'h0000_0055;
    #1;
    chk("delay ack pc_en", {31'd0, pc_en}, 32'd1);
    @(posedge clk);
    #1;
    chk("delay inst", inst, 32'h55);
    chk("delay inst_pc", inst_pc, 32'h200);
    chk("delay valid", {31'd0, valid}, 32'd1);

    // Reset in the middle of a request; acks during and just after reset are ignored.
    @(negedge clk);
    pc_in = 32'h204; ack = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst req before", {31'd0, req}, 32'd1);
    @(negedge clk);
    rst = 1'b1; ack = 1'b1; data = 32'hFFFF_0000;
    #1;
    chk("midrst req async", {31'd0, req}, 32'd0);
    chk("midrst valid async", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst valid after", {31'd0, valid}, 32'd0);
    chk("midrst req after", {31'd0, req}, 32'd1);
    chk("midrst addr after", addr, 32'h204);

`ifdef FETCH_TIMEOUT_EN
    pc_in = 32'h300;
    do_reset();
    @(posedge clk);
    #1;
    chk("to req start", {31'd0, req}, 32'd1);
    for (int i = 1; i < 255; i++) begin
      @(posedge clk);
      #1;
      chk("to waiting", {30'd0, req, err}, 32'd2);
    end
    @(posedge clk);
    #1;
    chk("to expire req", {31'd0, req}, 32'd0);
    chk("to expire err", {31'd0, err}, 32'd1);
    @(posedge clk);
    #1;
    chk("to reissue req", {31'd0, req}, 32'd1);
    chk("to reissue addr", addr, 32'h300);
    chk("to sticky err", {31'd0, err}, 32'd1);
`else
    @(negedge clk);
    ack = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      chk("noto waiting", {30'd0, req, err}, 32'd2);
    end
`endif

    // Randomized run against a transaction-level model.
    pcreg = 32'h1000;
    pc_in = pcreg;
    do_reset();
    m_req = 1'b0; m_kill = 1'b0; m_valid = 1'b0;
    m_addr = 32'd0; m_inst = 32'd0; m_ipc = 32'd0;
    held_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 11) == 0);
      ack   = ($urandom_range(0, 9) < 4);
      data  = $urandom;
      pc_in = pcreg | 32'($urandom_range(0, 3));
      e_pc_en = flush || (m_req && ack && !m_kill && !stall) || ((held_q.size() != 0) && !stall);
      #1;
      chk("rnd pc_en", {31'd0, pc_en}, {31'd0, e_pc_en});

      if (held_q.size() != 0) begin
        if (flush) held_q.delete();
        else if (!stall) begin
          m_inst = held_q[0].data; m_ipc = held_q[0].pc; m_valid = 1'b1;
          held_q.delete();
        end
      end else if (m_req) begin
        if (ack) begin
          if (flush) begin
            m_req = 1'b0; m_kill = 1'b0;
          end else if (m_kill) begin
            m_kill = 1'b0; m_addr = pc_in & 32'hFFFF_FFFC;
          end else if (!stall) begin
            m_inst = data; m_ipc = m_addr; m_valid = 1'b1; m_req = 1'b0;
          end else begin
            held_q.push_back('{data, m_addr});
            m_req = 1'b0;
          end
        end else if (flush) m_kill = 1'b1;
      end else if (!flush) begin
        m_req = 1'b1; m_addr = pc_in & 32'hFFFF_FFFC;
      end
      if (flush) begin
        m_valid = 1'b0; m_inst = 32'd0;
      end

      @(posedge clk);
      #1;
      chk("rnd req", {31'd0, req}, {31'd0, m_req});
      chk("rnd addr", addr, m_addr);
      chk("rnd valid", {31'd0, valid}, {31'd0, m_valid});
      chk("rnd inst", inst, m_inst);
      chk("rnd inst_pc", inst_pc, m_ipc);
      chk("rnd err", {31'd0, err}, 32'd0);

      if (e_pc_en) pcreg = flush ? ($urandom & 32'hFFFF_FFFC) : (pcreg + 32'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction-fetch controller sitting between the PC register and instruction memory. Consumes the PC value, issues word fetches over a req/ack handshake with variable latency, and presents the fetched instruction plus its address to the IF/ID boundary. Supplies the PC write enable, honours hazard stalls and branch flushes, and discards in-flight responses killed by a flush.

## Interface
- No parameters.
- `clk_i` in 1: clock, all state updates on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `pc_i` in 32: current PC value, fetch address.
- `pc_en_o` out 1: PC write enable, one-cycle pulse; PC loads its next value on that edge.
- `stall_i` in 1: hazard detection, hold IF/ID outputs.
- `flush_i` in 1: branch taken, squash fetched instruction and in-flight fetch.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 32: fetch address, word-aligned.
- `imem_ack_i` in 1: response valid, sampled only while `imem_req_o`=1.
- `imem_data_i` in 32: instruction word, valid with `imem_ack_i`.
- `inst_o` out 32: instruction to ID.
- `inst_pc_o` out 32: address of `inst_o`.
- `inst_valid_o` out 1: `inst_o` is live.
- `fetch_err_o` out 1: fetch timeout sticky flag (see Configuration).

## Operation
- States: IDLE, REQ, HOLD.
- Reset values: state IDLE; `imem_req_o`=0; `imem_addr_o`=0; `pc_en_o`=0; `inst_o`=0 (NOP); `inst_pc_o`=0; `inst_valid_o`=0; kill flag=0; skid register=0; `fetch_err_o`=0.
- IDLE -> REQ unconditionally one cycle after reset release: latch `imem_addr_o`={`pc_i`[31:2],2'b00}, assert `imem_req_o`.
- REQ, no ack: hold `imem_req_o`=1 and `imem_addr_o` stable.
- REQ, ack, kill flag set: drop data, clear kill, re-latch `imem_addr_o` from `pc_i`, stay REQ.
- REQ, ack, kill clear, `stall_i`=0: load `inst_o`=`imem_data_i`, `inst_pc_o`=`imem_addr_o`, `inst_valid_o`=1; pulse `pc_en_o`; drop `imem_req_o`; go IDLE (next request issued the following cycle with the updated `pc_i`).
- REQ, ack, kill clear, `stall_i`=1: capture data/addr into skid register, drop `imem_req_o`, go HOLD; outputs unchanged.
- HOLD, `stall_i`=1: hold everything.
- HOLD, `stall_i`=0: move skid to outputs, `inst_valid_o`=1, pulse `pc_en_o`, go IDLE.
- `flush_i`=1 (priority over stall, any state): next edge `inst_valid_o`=0, `inst_o`=0, `pc_en_o` pulsed so PC loads the branch target; REQ without ack same cycle -> set kill; REQ with ack same cycle -> data dropped, go IDLE; HOLD -> skid discarded, go IDLE.
- `stall_i`=1 in IDLE/REQ: outputs held; fetch proceeds into skid as above.
- `pc_en_o` never asserted while `stall_i`=1 unless `flush_i`=1.

## Timing
- `imem_req_o` and `imem_addr_o` registered; ack accepted in any cycle with req high, including the first.
- Ack-to-output latency: 1 edge. Zero-wait memory throughput: 1 instruction per 2 cycles.
- `pc_en_o` is a single-cycle pulse coincident with the output update edge.
- Reset asserted mid-request: all state cleared immediately; any ack arriving during or after reset, before a new request, is ignored.

## Configuration
- `FETCH_TIMEOUT_EN` defined: 8-bit counter runs in REQ, cleared on ack or state exit; reaching 255 without ack sets `fetch_err_o` (sticky until reset), drops the request, and reissues it from `pc_i` next cycle.
- Undefined: no counter; REQ waits indefinitely; `fetch_err_o` tied 0.

## Test plan
- Reset release, `pc_i`=0, mem ack 1 cycle after req with 0x20020005 -> `imem_addr_o`=0, then `inst_o`=0x20020005, `inst_pc_o`=0, `inst_valid_o`=1, one `pc_en_o` pulse.
- Ack delayed 5 cycles -> `imem_req_o` high and `imem_addr_o` stable 6 cycles, no `pc_en_o` until ack edge.
- `stall_i` high 3 cycles across ack -> outputs unchanged, state HOLD; on release skid word appears, `pc_en_o` pulses once.
- `flush_i` in REQ before ack, `pc_i` then 0x40 -> `inst_valid_o`=0, late ack dropped, next `imem_addr_o`=0x40.
- `flush_i` and `stall_i` together with valid output -> flush wins: `inst_valid_o`=0, `pc_en_o` pulses.
- With `FETCH_TIMEOUT_EN`, no ack for 255 cycles -> `fetch_err_o`=1, request reissued; without macro, `fetch_err_o`=0 and req held.
